// File: rtl/uart_rx.sv
// uart_rx: oversampling serial receiver with its own baud-tick generator.
// The default build receives 8N1 frames, LSB first. Defining UART_RX_PARITY_EN
// switches to 8E1 framing and adds the o_parity_err output.
// rx_done / frame_err / parity_err are single-cycle registered pulses.
module uart_rx #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rx,
   output logic [7:0] o_rx_data,
   output logic       o_rx_done,
   output logic       o_rx_busy,
`ifdef UART_RX_PARITY_EN
   output logic       o_parity_err,
`endif
   output logic       o_frame_err
);

   localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TW  = $clog2(OVERSAMPLE);
   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic            rx_meta_q, rx_s_q;
   logic [DW-1:0]   div_cnt_q;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            done_q, done_d;
   logic            ferr_q, ferr_d;
   logic            busy_q;
   logic            tick_s, half_s, full_s;
`ifdef UART_RX_PARITY_EN
   logic            par_q, par_d;
   logic            perr_q, perr_d;
`endif

   assign tick_s = (div_cnt_q == DIV_LAST);
   assign half_s = tick_s && (tcnt_q == HALF_LAST);
   assign full_s = tick_s && (tcnt_q == FULL_LAST);

   // Two-flop synchroniser for the asynchronous line; idles high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= i_rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Free-running oversample tick divider, active in every state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt_q <= '0;
      end else if (tick_s) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_q + DW'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: frame sequencing on tick boundaries.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (tick_s && !rx_s_q) state_d = S_START;
            else                   state_d = S_IDLE;
         end
         S_START: begin
            if (half_s) state_d = rx_s_q ? S_IDLE : S_DATA;
            else        state_d = S_START;
         end
         S_DATA: begin
`ifdef UART_RX_PARITY_EN
            if (full_s && (idx_q == 3'd7)) state_d = S_PARITY;
`else
            if (full_s && (idx_q == 3'd7)) state_d = S_STOP;
`endif
            else                           state_d = S_DATA;
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (full_s) state_d = S_STOP;
            else        state_d = S_PARITY;
         end
`endif
         S_STOP: begin
            if (full_s) state_d = rx_s_q ? S_IDLE : S_BREAK;
            else        state_d = S_STOP;
         end
         S_BREAK: begin
            // A line held low must return high before a new start is seen.
            if (tick_s && rx_s_q) state_d = S_IDLE;
            else                  state_d = S_BREAK;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath logic: tick counting, bit capture and result pulses.
   always_comb begin
      tcnt_d  = tcnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            tcnt_d = '0;
            idx_d  = 3'd0;
         end
         S_START: begin
            if (half_s) begin
               tcnt_d = '0;
               idx_d  = 3'd0;
            end else if (tick_s) begin
               tcnt_d = tcnt_q + TW'(1);
            end else begin
               tcnt_d = tcnt_q;
            end
         end
         S_DATA: begin
            if (full_s) begin
               tcnt_d          = '0;
               shift_d[idx_q]  = rx_s_q;
               idx_d           = idx_q + 3'd1;
            end else if (tick_s) begin
               tcnt_d = tcnt_q + TW'(1);
            end else begin
               tcnt_d = tcnt_q;
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (full_s) begin
               tcnt_d = '0;
               par_d  = rx_s_q;
            end else if (tick_s) begin
               tcnt_d = tcnt_q + TW'(1);
            end else begin
               tcnt_d = tcnt_q;
            end
         end
`endif
         S_STOP: begin
            if (full_s) begin
               tcnt_d = '0;
               if (!rx_s_q) begin
                  ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (^{shift_q, par_q}) begin
                  perr_d = 1'b1;
`endif
               end else begin
                  done_d = 1'b1;
                  data_d = shift_q;
               end
            end else if (tick_s) begin
               tcnt_d = tcnt_q + TW'(1);
            end else begin
               tcnt_d = tcnt_q;
            end
         end
         S_BREAK: tcnt_d = '0;
         default: tcnt_d = '0;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt_q  <= '0;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         tcnt_q  <= tcnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         busy_q  <= (state_d != S_IDLE);
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign o_rx_data   = data_q;
   assign o_rx_done   = done_q;
   assign o_frame_err = ferr_q;
   assign o_rx_busy   = busy_q;
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = perr_q;
`endif

endmodule
